mult_resolve_q: RTL

- Final stage of the multiplier pipeline. Takes the 2W-bit sign-magnitude product from stage 2 and resolves it into a W-bit writeback value using one of four result modes.
- Flags signed overflow and buffers results in a DEPTH-entry queue with valid/ready handshakes on both sides, so a stalled writeback arbiter does not lose multiplier results.
- Successor to the fixed 32-bit, unbuffered, check-only last stage.

---
 rtl/mult_resolve_q_if.sv | 31 +++
 rtl/mult_resolve_q.sv | 109 ++++++++++
 2 files changed

// File: rtl/mult_resolve_q_if.sv
// Handshake bundle for the final multiplier stage: stage-2 product in, resolved writeback out.
interface mult_resolve_q_if #(parameter int W = 32);
    logic           m2_m3_oper;
    logic           m2_m3_ready;
    logic [2*W-1:0] m2_m3_multres;
    logic [4:0]     m2_m3_regdest;
    logic           m2_m3_ispositive;
    logic           m2_m3_iszero;
    logic [1:0]     m2_m3_mode;
    logic           m3_mul_valid;
    logic           wb_ready;
    logic [4:0]     m3_mul_regdest;
    logic           m3_mul_writereg;
    logic [W-1:0]   m3_mul_wbvalue;
    logic           m3_mul_overflow;
    logic [31:0]    m3_ovf_count;

    modport slave (
        input  m2_m3_oper, m2_m3_multres, m2_m3_regdest, m2_m3_ispositive,
               m2_m3_iszero, m2_m3_mode, wb_ready,
        output m2_m3_ready, m3_mul_valid, m3_mul_regdest, m3_mul_writereg,
               m3_mul_wbvalue, m3_mul_overflow, m3_ovf_count
    );

    modport master (
        output m2_m3_oper, m2_m3_multres, m2_m3_regdest, m2_m3_ispositive,
               m2_m3_iszero, m2_m3_mode, wb_ready,
        input  m2_m3_ready, m3_mul_valid, m3_mul_regdest, m3_mul_writereg,
               m3_mul_wbvalue, m3_mul_overflow, m3_ovf_count
    );
endinterface

// File: rtl/mult_resolve_q.sv
// Multiplier final stage: resolves a sign-magnitude product per result mode into a FIFO.
// Optional overflow event counter enabled by defining MULT_RESOLVE_STATS_EN.
module mult_resolve_q #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    mult_resolve_q_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]    FULL    = (AW+1)'(DEPTH);
    localparam logic [2*W-1:0] MAX_POS = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [2*W-1:0] MIN_MAG = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic [4:0]   regdest;
        logic         writereg;
        logic [W-1:0] wbvalue;
        logic         overflow;
    } entry_t;

    logic [2*W:0] prod;
    logic         ovf;
    entry_t       res;

    always_comb begin
        prod = '0;
        if (!bus.m2_m3_iszero)
            prod = bus.m2_m3_ispositive ? {1'b0, bus.m2_m3_multres}
                                        : -{1'b0, bus.m2_m3_multres};
        // Negative side reaches one further: magnitude 2^(W-1) is still representable.
        ovf = !bus.m2_m3_iszero &&
              (bus.m2_m3_ispositive ? (bus.m2_m3_multres > MAX_POS)
                                    : (bus.m2_m3_multres > MIN_MAG));
        res.regdest  = bus.m2_m3_regdest;
        res.writereg = 1'b1;
        res.wbvalue  = prod[W-1:0];
        res.overflow = ovf;
        case (bus.m2_m3_mode)
            2'b00: if (ovf) begin
                res.writereg = 1'b0;
                res.wbvalue  = '0;
            end
            2'b10: begin
                res.wbvalue  = prod[2*W-1:W];
                res.overflow = 1'b0;
            end
            2'b11: if (ovf)
                res.wbvalue = bus.m2_m3_ispositive ? {1'b0, {(W-1){1'b1}}}
                                                   : {1'b1, {(W-1){1'b0}}};
            default: ;
        endcase
    end

    entry_t        mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          valid, push, pop;
    entry_t        head;

    assign valid           = (count != '0);
    assign bus.m2_m3_ready = (count != FULL);
    assign push            = bus.m2_m3_oper && bus.m2_m3_ready;
    assign pop             = valid && bus.wb_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) mem[wptr] <= res;
    end

    assign head                = mem[rptr];
    assign bus.m3_mul_valid    = valid;
    assign bus.m3_mul_regdest  = valid ? head.regdest  : '0;
    assign bus.m3_mul_writereg = valid ? head.writereg : 1'b0;
    assign bus.m3_mul_wbvalue  = valid ? head.wbvalue  : '0;
    assign bus.m3_mul_overflow = valid ? head.overflow : 1'b0;

`ifdef MULT_RESOLVE_STATS_EN
    logic [31:0] ovf_count;

    // HIGH entries carry overflow=0, so they never count.
    always_ff @(posedge clock) begin
        if (reset)
            ovf_count <= '0;
        else if (push && res.overflow && ovf_count != '1)
            ovf_count <= ovf_count + 1'b1;
    end

    assign bus.m3_ovf_count = ovf_count;
`else
    assign bus.m3_ovf_count = '0;
`endif
endmodule
